// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line.
// Each bit is sampled at its centre using clk_bit system clocks per serial bit.
module uart_rx #(
    parameter int unsigned clk_bit = 87
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error
);

    localparam int unsigned      CNT_W    = $clog2(clk_bit);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((clk_bit - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(clk_bit - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_d;
    logic             valid_d;
    logic             ferr_d;
    logic             rx_meta;
    logic             rx_s;

    // Two-flop synchroniser; resets to the idle level so reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_data;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data          <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data          <= data_d;
            data_valid    <= valid_d;
            framing_error <= ferr_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            // Re-check the line half a bit in so short low glitches are dropped.
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Decision at stop-bit centre; IDLE is re-entered mid-stop for back-to-back frames.
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A held-low line (break) must return high before another frame is accepted.
            BREAK_WAIT: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one instance at 87 clocks/bit, one at 16 clocks/bit.
module tb_uart_rx;

    localparam int unsigned CB0 = 87;
    localparam int unsigned CB1 = 16;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] line;
    logic [7:0] dout [2];
    logic       dv   [2];
    logic       fe   [2];

    always #50 clk = ~clk;

    uart_rx #(.clk_bit(CB0)) u_rx0 (
        .i_clk(clk), .i_rst(rst[0]), .i_data(line[0]),
        .data(dout[0]), .data_valid(dv[0]), .framing_error(fe[0])
    );

    uart_rx #(.clk_bit(CB1)) u_rx1 (
        .i_clk(clk), .i_rst(rst[1]), .i_data(line[1]),
        .data(dout[1]), .data_valid(dv[1]), .framing_error(fe[1])
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed output events
    logic [7:0]  obs_d0 [$];
    logic [7:0]  obs_d1 [$];
    int unsigned obs_c0 [$];
    int          n_fe [2] = '{0, 0};
    int          n_both = 0;

    always @(negedge clk) begin
        if (dv[0] === 1'b1) begin
            obs_d0.push_back(dout[0]);
            obs_c0.push_back(cyc);
        end
        if (dv[1] === 1'b1) obs_d1.push_back(dout[1]);
        for (int k = 0; k < 2; k++) begin
            if (fe[k] === 1'b1) n_fe[k]++;
            if (dv[k] === 1'b1 && fe[k] === 1'b1) n_both++;
        end
    end

    // Reference model state: what a correct receiver must have produced
    logic [7:0]  exp_d0 [$];
    logic [7:0]  exp_d1 [$];
    int unsigned start_c0 [$];
    int          exp_fe [2] = '{0, 0};
    logic [7:0]  exp_data [2] = '{8'h00, 8'h00};

    typedef struct {
        int         sel;
        logic [7:0] b;
        logic       stop;
        int         hold;
        int         gap;
        bit         ckpt;
        bit         exp_valid;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned cbof(input int s);
        return (s == 0) ? CB0 : CB1;
    endfunction

    task automatic drive(input int s, input logic v, input int unsigned n);
        if (s == 0) line[0] = v;
        else        line[1] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input int s, input logic [7:0] b, input bit good, input bit bad);
        if (good) begin
            if (s == 0) exp_d0.push_back(b);
            else        exp_d1.push_back(b);
            exp_data[s] = b;
        end
        if (bad) exp_fe[s]++;
    endtask

    task automatic send_frame(input int s, input logic [7:0] b, input logic stop,
                              input int hold, input int gap);
        int unsigned cb;
        cb = cbof(s);
        if (s == 0 && stop) start_c0.push_back(cyc);
        drive(s, 1'b0, cb);
        for (int i = 0; i < 8; i++) drive(s, b[i], cb);
        if (stop) begin
            drive(s, 1'b1, cb);
            if (gap > 0) drive(s, 1'b1, cb * gap);
        end else begin
            drive(s, 1'b0, cb * hold);
            drive(s, 1'b1, cb * ((gap > 0) ? gap : 1));
        end
    endtask

    task automatic checkpoint(input int s, input string tag);
        int          n_obs;
        int          n_exp;
        logic [7:0]  od;
        logic [7:0]  ed;
        int unsigned lo;
        int unsigned hi;
        int unsigned lat;
        repeat (2) @(posedge clk);
        #1;
        lo = (19 * cbof(s)) / 2;
        hi = lo + 6;
        if (s == 0) begin
            n_obs = obs_d0.size();
            n_exp = exp_d0.size();
            chk({tag, " pulse count"}, 32'(n_obs), 32'(n_exp));
            while (obs_d0.size() > 0 && exp_d0.size() > 0) begin
                od = obs_d0.pop_front();
                ed = exp_d0.pop_front();
                chk({tag, " byte at pulse"}, 32'(od), 32'(ed));
                if (obs_c0.size() > 0 && start_c0.size() > 0) begin
                    lat = obs_c0.pop_front() - start_c0.pop_front();
                    chk({tag, " latency in window"}, 32'(lat >= lo && lat <= hi), 32'd1);
                end
            end
            obs_d0.delete(); exp_d0.delete(); obs_c0.delete(); start_c0.delete();
        end else begin
            n_obs = obs_d1.size();
            n_exp = exp_d1.size();
            chk({tag, " pulse count"}, 32'(n_obs), 32'(n_exp));
            while (obs_d1.size() > 0 && exp_d1.size() > 0) begin
                od = obs_d1.pop_front();
                ed = exp_d1.pop_front();
                chk({tag, " byte at pulse"}, 32'(od), 32'(ed));
            end
            obs_d1.delete(); exp_d1.delete();
        end
        chk({tag, " framing_error count"}, 32'(n_fe[s]), 32'(exp_fe[s]));
        chk({tag, " data held"}, 32'(dout[s]), 32'(exp_data[s]));
        chk({tag, " valid/ferr overlap"}, 32'(n_both), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        logic [7:0] abort_b;

        rst  = 2'b11;
        line = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset data[%0d]", k), 32'(dout[k]), 32'h00);
            chk($sformatf("reset valid[%0d]", k), 32'(dv[k]), 32'd0);
            chk($sformatf("reset ferr[%0d]", k), 32'(fe[k]), 32'd0);
        end
        rst = 2'b00;
        drive(0, 1'b1, 4);

        // sel, byte, stop, hold, gap, ckpt, exp_valid, exp_ferr
        vecs.push_back('{0, 8'h56, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{0, 8'h00, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{0, 8'hFF, 1'b1, 1, 0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{0, 8'hA5, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{0, 8'h12, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{0, 8'h34, 1'b0, 3, 1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{0, 8'h78, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1, 8'h81, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            send_frame(vecs[i].sel, vecs[i].b, vecs[i].stop, vecs[i].hold, vecs[i].gap);
            model_frame(vecs[i].sel, vecs[i].b, vecs[i].exp_valid, vecs[i].exp_ferr);
            if (vecs[i].ckpt) checkpoint(vecs[i].sel, $sformatf("vec%0d", i));
        end

        // Start glitch shorter than half a bit must be ignored
        drive(0, 1'b0, 20);
        drive(0, 1'b1, 2 * CB0);
        checkpoint(0, "glitch");
        send_frame(0, 8'h3C, 1'b1, 1, 1);
        model_frame(0, 8'h3C, 1'b1, 1'b0);
        checkpoint(0, "after glitch");

        // Reset during bit 4; remaining bits are high so no new start is seen
        abort_b = 8'hF5;
        drive(0, 1'b0, CB0);
        for (int i = 0; i < 4; i++) drive(0, abort_b[i], CB0);
        drive(0, abort_b[4], CB0 / 2);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-frame reset data", 32'(dout[0]), 32'h00);
        chk("mid-frame reset valid", 32'(dv[0]), 32'd0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        drive(0, 1'b1, CB0 - CB0 / 2 - 2);
        drive(0, 1'b1, 5 * CB0);
        exp_data[0] = 8'h00;
        checkpoint(0, "mid-frame reset");
        send_frame(0, 8'hC3, 1'b1, 1, 1);
        model_frame(0, 8'hC3, 1'b1, 1'b0);
        checkpoint(0, "after reset");

        // Randomized frames against the model
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 16; r++) begin
                int hold;
                int gap;
                rb    = 8'($urandom);
                rstop = ($urandom_range(0, 5) != 0);
                hold  = int'($urandom_range(1, 2));
                gap   = int'($urandom_range(0, 2));
                send_frame(s, rb, rstop, hold, gap);
                model_frame(s, rb, rstop, !rstop);
                if ((r % 4) == 3) checkpoint(s, $sformatf("rand%0d_%0d", s, r));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
